decode_pipe: RTL and testbench
==============================

// Module: decode_pipe
// PURPOSE
//  Registered MIPS decode stage with a valid/ready handshake; successor to the combinational decoder.
//  Sits between fetch and execute. It decodes one 32-bit instruction per accepted transfer into
//  ALU/memory/writeback controls, register-file read addresses, the destination register, the
//  extended immediate and the jump target. It inserts a one-cycle load-use bubble and flags
//  illegal encodings.
//  The register file is external; decode_pipe exports read addresses only.
// PARAMETERS
//  XLEN      32  width of pc, imm and target datapaths (>=32; upper bits extend per imm rules)
//  RA_W      5   register address width
//  ALUOP_W   6   aluop width; codes = R-type funct / I-type opcode values, as in existing decoder
//  LINK_REG  31  destination register for JAL
// PORTS
//  clock       in   1        rising-edge clock
//  reset       in   1        synchronous, active-high
//  in_valid    in   1        fetch presents in_pc/in_insn
//  in_ready    out  1        decode accepts this cycle (combinational)
//  in_pc       in   XLEN     pc of instruction
//  in_insn     in   32       instruction word
//  flush       in   1        discard held and incoming instruction (branch redirect)
//  out_valid   out  1        output register holds a decoded instruction
//  out_ready   in   1        execute accepts this cycle
//  out_pc      out  XLEN     registered pc
//  out_rs      out  RA_W     read port 1 address (insn[25:21]; 0 for LUI/J/JAL)
//  out_rt      out  RA_W     read port 2 address (insn[20:16]; 0 when unused)
//  out_dst     out  RA_W     write address
//  out_imm     out  XLEN     extended immediate
//  out_target  out  XLEN     {pc+4[XLEN-1:28], insn[25:0], 2'b00} for J/JAL, else 0
//  out_br, out_jp, out_aluinb, out_dmwe, out_rwe, out_rwd  out 1  controls as existing decoder
//  out_aluop   out  ALUOP_W  ALU operation
//  out_illegal out  1        unknown opcode/funct; all write enables forced 0
// BEHAVIOUR
//  - Reset: out_valid=0; every other output register=0; in_ready=0 during reset.
//  - Latency 1: instruction accepted at edge N appears on outputs after edge N.
//  - Transfers: in_valid&in_ready and out_valid&out_ready.
//  - in_ready = !reset & !flush & !hazard & (!out_valid | out_ready).
//  - Output hold: outputs are stable while out_valid & !out_ready.
//    If the output is accepted and no input is accepted in the same cycle, out_valid <= 0.
//  - Load-use hazard: hazard = out_valid & out_rwd & out_rwe & out_dst!=0 & (in_rs==out_dst |
//    (in uses rt & in_rt==out_dst)).
//    "Uses rt" = R-type ALU, SW, SB, BEQ, BNE.
//    While the hazard holds, in_ready=0. Once the load is accepted, exactly one bubble follows
//    (out_valid=0), then the stalled instruction is accepted.
//  - Destination select:
//    - R-type and JALR: rd=insn[15:11].
//    - I-type ALU and loads: rt.
//    - JAL: LINK_REG, with rwe=1.
//    - Stores, branches, J, JR: dst=0, rwe=0.
//    - If dst==0, rwe is forced 0.
//  - Immediate:
//    - Sign-extend insn[15:0] for ADDI/ADDIU/SLTI/SLTIU/loads/stores/branches.
//    - Zero-extend for ORI/XORI/ANDI.
//    - LUI: {insn[15:0],16'b0}, then sign-extended to XLEN.
//  - Encoding rules:
//    - REGIMM opcode 000001 decodes BLTZ/BGEZ via insn[20:16]; other rt values are illegal.
//    - All-zero word is a valid NOP: rwe=0, dmwe=0, illegal=0.
//    - Shift-immediate forms (SLL/SRL/SRA) use shamt insn[10:6] in out_imm[4:0], with aluinb=1.
//  - Flush: out_valid<=0 next edge regardless of out_ready; no input is accepted that cycle.
//    reset has priority over flush; flush has priority over hazard.
// CONFIGURATION
//  DECODE_MULDIV_EN defined:
//   - MULT/MULTU/DIV/DIVU/MUL(op 011100) decode with rwe=0, writing HI/LO downstream.
//   - MFHI/MFLO decode with rwe=1, dst=rd, rwd=0.
//  Undefined:
//   - All seven encodings above assert out_illegal=1 with all write enables 0.
// TESTING
//  1 reset 3 cycles, in_valid=1 -> in_ready=0, out_valid=0, all outputs 0; first insn out 1 cycle after release
//  2 ADDI $5,$0,-4 (0x2005FFFC) -> out_dst=5, out_rwe=1, out_aluinb=1, out_imm=0xFFFFFFFC
//  3 LW $8,0($9) then ADD $10,$8,$2 -> in_ready=0 while LW held, one bubble, ADD out with out_rs=8, out_dst=10
//  4 out_ready=0 for 4 cycles with ORI $3,$3,0x8000 held -> outputs stable, out_imm=0x00008000, in_ready=0
//  5 JAL 0x0100000 at pc=0x00400000 -> out_dst=31, out_jp=1, out_target=0x00400000; flush next cycle -> out_valid=0
//  6 MULT $4,$5 (0x00850018) -> macro on: illegal=0, rwe=0; macro off: out_illegal=1, dmwe=rwe=0

Source files
------------

// File: rtl/decode_pipe_if.sv
// Fetch -> decode -> execute handshake bundle for decode_pipe.
// master: the fetch/execute environment; slave: the decode stage itself.
interface decode_pipe_if #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc;
    logic [31:0]        in_insn;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [RA_W-1:0]    out_rs;
    logic [RA_W-1:0]    out_rt;
    logic [RA_W-1:0]    out_dst;
    logic [XLEN-1:0]    out_imm;
    logic [XLEN-1:0]    out_target;
    logic               out_br;
    logic               out_jp;
    logic               out_aluinb;
    logic               out_dmwe;
    logic               out_rwe;
    logic               out_rwd;
    logic [ALUOP_W-1:0] out_aluop;
    logic               out_illegal;

    modport master (
        output in_valid, in_pc, in_insn, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs, out_rt, out_dst, out_imm,
               out_target, out_br, out_jp, out_aluinb, out_dmwe, out_rwe,
               out_rwd, out_aluop, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_insn, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs, out_rt, out_dst, out_imm,
               out_target, out_br, out_jp, out_aluinb, out_dmwe, out_rwe,
               out_rwd, out_aluop, out_illegal
    );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: registered MIPS decode stage with valid/ready handshake.
// Decodes one instruction per accepted transfer, inserts a single load-use
// bubble and flags illegal encodings with all write enables cleared.
// Optional feature macro: DECODE_MULDIV_EN (MULT/MULTU/DIV/DIVU/MUL/MFHI/MFLO).
module decode_pipe #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int ALUOP_W  = 6,
    parameter int LINK_REG = 31
) (
    input logic          clock,
    input logic          reset,
    decode_pipe_if.slave bus
);
    localparam int HI_W = XLEN - 28;

    logic [5:0]         op;
    logic [5:0]         fn;
    logic [RA_W-1:0]    f_rs;
    logic [RA_W-1:0]    f_rt;
    logic [RA_W-1:0]    f_rd;
    logic signed [15:0] imm16;
    logic signed [31:0] lui_w;
    logic [XLEN-1:0]    imm_s;
    logic [XLEN-1:0]    imm_z;
    logic [XLEN-1:0]    imm_lui;
    logic [HI_W-1:0]    pc_hi;
    logic [XLEN-1:0]    tgt;

    assign op      = bus.in_insn[31:26];
    assign fn      = bus.in_insn[5:0];
    assign f_rs    = RA_W'(bus.in_insn[25:21]);
    assign f_rt    = RA_W'(bus.in_insn[20:16]);
    assign f_rd    = RA_W'(bus.in_insn[15:11]);
    assign imm16   = bus.in_insn[15:0];
    assign lui_w   = {bus.in_insn[15:0], 16'h0000};
    assign imm_s   = XLEN'(imm16);
    assign imm_z   = XLEN'(bus.in_insn[15:0]);
    assign imm_lui = XLEN'(lui_w);
    // upper bits of pc+4: only a carry out of bits [27:2] can change them
    assign pc_hi   = bus.in_pc[XLEN-1:28] + HI_W'(&bus.in_pc[27:2]);
    assign tgt     = {pc_hi, bus.in_insn[25:0], 2'b00};

    logic               ill;
    logic               wr;
    logic [RA_W-1:0]    d_rs;
    logic [RA_W-1:0]    d_rt;
    logic [RA_W-1:0]    d_dst;
    logic [XLEN-1:0]    d_imm;
    logic [XLEN-1:0]    d_target;
    logic               d_br;
    logic               d_jp;
    logic               d_aluinb;
    logic               d_dmwe;
    logic               d_rwe;
    logic               d_rwd;
    logic [ALUOP_W-1:0] d_aluop;
    logic               d_uses_rt;

    // Instruction decode of the word presented by fetch.
    always_comb begin
        ill       = 1'b0;
        wr        = 1'b0;
        d_rs      = '0;
        d_rt      = '0;
        d_dst     = '0;
        d_imm     = '0;
        d_target  = '0;
        d_br      = 1'b0;
        d_jp      = 1'b0;
        d_aluinb  = 1'b0;
        d_dmwe    = 1'b0;
        d_rwd     = 1'b0;
        d_uses_rt = 1'b0;
        d_aluop   = ALUOP_W'(op);
        case (op)
            6'h00: begin
                d_aluop = ALUOP_W'(fn);
                d_rs    = f_rs;
                case (fn)
                    6'h00, 6'h02, 6'h03: begin
                        d_rt      = f_rt;
                        d_dst     = f_rd;
                        wr        = 1'b1;
                        d_aluinb  = 1'b1;
                        d_imm     = XLEN'(bus.in_insn[10:6]);
                        d_uses_rt = 1'b1;
                    end
                    6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        d_rt      = f_rt;
                        d_dst     = f_rd;
                        wr        = 1'b1;
                        d_uses_rt = 1'b1;
                    end
                    6'h08: d_jp = 1'b1;
                    6'h09: begin
                        d_jp  = 1'b1;
                        d_dst = f_rd;
                        wr    = 1'b1;
                    end
`ifdef DECODE_MULDIV_EN
                    6'h10, 6'h12: begin
                        d_dst = f_rd;
                        wr    = 1'b1;
                    end
                    6'h18, 6'h19, 6'h1a, 6'h1b: d_rt = f_rt;
`endif
                    default: ill = 1'b1;
                endcase
            end
            6'h01: begin
                d_rs  = f_rs;
                d_br  = 1'b1;
                d_imm = imm_s;
                if (bus.in_insn[20:17] != 4'b0000) ill = 1'b1;
            end
            6'h02: begin
                d_jp     = 1'b1;
                d_target = tgt;
            end
            6'h03: begin
                d_jp     = 1'b1;
                d_target = tgt;
                d_dst    = RA_W'(LINK_REG);
                wr       = 1'b1;
            end
            6'h04, 6'h05: begin
                d_rs      = f_rs;
                d_rt      = f_rt;
                d_br      = 1'b1;
                d_imm     = imm_s;
                d_uses_rt = 1'b1;
            end
            6'h06, 6'h07: begin
                d_rs  = f_rs;
                d_br  = 1'b1;
                d_imm = imm_s;
            end
            6'h08, 6'h09, 6'h0a, 6'h0b: begin
                d_rs     = f_rs;
                d_dst    = f_rt;
                wr       = 1'b1;
                d_aluinb = 1'b1;
                d_imm    = imm_s;
            end
            6'h0c, 6'h0d, 6'h0e: begin
                d_rs     = f_rs;
                d_dst    = f_rt;
                wr       = 1'b1;
                d_aluinb = 1'b1;
                d_imm    = imm_z;
            end
            6'h0f: begin
                d_dst    = f_rt;
                wr       = 1'b1;
                d_aluinb = 1'b1;
                d_imm    = imm_lui;
            end
`ifdef DECODE_MULDIV_EN
            6'h1c: begin
                d_rs = f_rs;
                d_rt = f_rt;
                if (fn != 6'h02) ill = 1'b1;
            end
`endif
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                d_rs     = f_rs;
                d_dst    = f_rt;
                wr       = 1'b1;
                d_rwd    = 1'b1;
                d_aluinb = 1'b1;
                d_imm    = imm_s;
            end
            6'h28, 6'h29, 6'h2b: begin
                d_rs      = f_rs;
                d_rt      = f_rt;
                d_dmwe    = 1'b1;
                d_aluinb  = 1'b1;
                d_imm     = imm_s;
                d_uses_rt = (op != 6'h29);
            end
            default: ill = 1'b1;
        endcase
        // an illegal word carries no controls at all, only the flag and pc
        if (ill) begin
            wr        = 1'b0;
            d_rs      = '0;
            d_rt      = '0;
            d_dst     = '0;
            d_imm     = '0;
            d_target  = '0;
            d_br      = 1'b0;
            d_jp      = 1'b0;
            d_aluinb  = 1'b0;
            d_dmwe    = 1'b0;
            d_rwd     = 1'b0;
            d_uses_rt = 1'b0;
            d_aluop   = '0;
        end
        d_rwe = wr & (d_dst != '0);
    end

    logic hazard;
    logic accept;

    // Load-use interlock against the load currently held in the output register.
    always_comb begin
        hazard = bus.out_valid & bus.out_rwd & bus.out_rwe & (bus.out_dst != '0) &
                 ((d_rs == bus.out_dst) | (d_uses_rt & (f_rt == bus.out_dst)));
    end

    assign bus.in_ready = !reset & !bus.flush & !hazard & (!bus.out_valid | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    // Output register: load on accept, drop valid on flush or on drain without refill.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_pc      <= '0;
            bus.out_rs      <= '0;
            bus.out_rt      <= '0;
            bus.out_dst     <= '0;
            bus.out_imm     <= '0;
            bus.out_target  <= '0;
            bus.out_br      <= 1'b0;
            bus.out_jp      <= 1'b0;
            bus.out_aluinb  <= 1'b0;
            bus.out_dmwe    <= 1'b0;
            bus.out_rwe     <= 1'b0;
            bus.out_rwd     <= 1'b0;
            bus.out_aluop   <= '0;
            bus.out_illegal <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid   <= 1'b1;
            bus.out_pc      <= bus.in_pc;
            bus.out_rs      <= d_rs;
            bus.out_rt      <= d_rt;
            bus.out_dst     <= d_dst;
            bus.out_imm     <= d_imm;
            bus.out_target  <= d_target;
            bus.out_br      <= d_br;
            bus.out_jp      <= d_jp;
            bus.out_aluinb  <= d_aluinb;
            bus.out_dmwe    <= d_dmwe;
            bus.out_rwe     <= d_rwe;
            bus.out_rwd     <= d_rwd;
            bus.out_aluop   <= d_aluop;
            bus.out_illegal <= ill;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_pipe.sv
// Testbench for decode_pipe: directed scenarios followed by random traffic,
// checked against an instruction-class reference model and a one-entry
// pipeline model of the handshake.
module tb_decode_pipe;
    logic clock = 1'b0;
    logic reset;

    decode_pipe_if bus ();

    decode_pipe dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [31:0] target;
        logic        br;
        logic        jp;
        logic        aluinb;
        logic        dmwe;
        logic        rwe;
        logic        rwd;
        logic [5:0]  aluop;
        logic        illegal;
    } dec_t;

    typedef enum logic [3:0] {
        K_ILL, K_RALU, K_SHIFTI, K_JR, K_JALR, K_MFHL, K_MULDIV, K_IALU_S,
        K_IALU_Z, K_LUI, K_LOAD, K_STORE, K_BR2, K_BR1, K_J, K_JAL
    } kind_t;

    localparam logic [5:0] RFN [24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h08, 6'h09, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h20, 6'h21,
        6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    localparam logic [5:0] IOP [24] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
        6'h07, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h1c,
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};

    int   n_vec = 0;
    int   n_err = 0;
    logic m_valid;
    logic m_rst;
    dec_t m_q;

`ifdef DECODE_MULDIV_EN
    localparam logic MD = 1'b1;
`else
    localparam logic MD = 1'b0;
`endif

    function automatic kind_t classify(input logic [31:0] w);
        logic [5:0] op = w[31:26];
        logic [5:0] fn = w[5:0];
        kind_t k = K_ILL;
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03}) k = K_SHIFTI;
            else if (fn inside {6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2a, 6'h2b}) k = K_RALU;
            else if (fn == 6'h08) k = K_JR;
            else if (fn == 6'h09) k = K_JALR;
            else if (MD && fn inside {6'h10, 6'h12}) k = K_MFHL;
            else if (MD && fn inside {[6'h18:6'h1b]}) k = K_MULDIV;
        end else if (op == 6'h01) begin
            if (w[20:16] inside {5'd0, 5'd1}) k = K_BR1;
        end else if (op == 6'h02) k = K_J;
        else if (op == 6'h03) k = K_JAL;
        else if (op inside {6'h04, 6'h05}) k = K_BR2;
        else if (op inside {6'h06, 6'h07}) k = K_BR1;
        else if (op inside {[6'h08:6'h0b]}) k = K_IALU_S;
        else if (op inside {[6'h0c:6'h0e]}) k = K_IALU_Z;
        else if (op == 6'h0f) k = K_LUI;
        else if (MD && op == 6'h1c && fn == 6'h02) k = K_MULDIV;
        else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) k = K_LOAD;
        else if (op inside {6'h28, 6'h29, 6'h2b}) k = K_STORE;
        return k;
    endfunction

    function automatic dec_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
        dec_t d = '0;
        kind_t k = classify(w);
        logic [31:0] pc4 = pc + 32'd4;
        d.pc = pc;
        if (k == K_ILL) begin
            d.illegal = 1'b1;
            return d;
        end
        d.aluop = (w[31:26] == 6'h00) ? w[5:0] : w[31:26];
        if (!(k inside {K_LUI, K_J, K_JAL})) d.rs = w[25:21];
        if (k inside {K_RALU, K_SHIFTI, K_STORE, K_BR2, K_MULDIV}) d.rt = w[20:16];
        if (k inside {K_RALU, K_SHIFTI, K_JALR, K_MFHL}) d.dst = w[15:11];
        if (k inside {K_IALU_S, K_IALU_Z, K_LUI, K_LOAD}) d.dst = w[20:16];
        if (k == K_JAL) d.dst = 5'd31;
        d.rwe    = (d.dst != 5'd0);
        d.rwd    = (k == K_LOAD);
        d.dmwe   = (k == K_STORE);
        d.br     = (k inside {K_BR1, K_BR2});
        d.jp     = (k inside {K_J, K_JAL, K_JR, K_JALR});
        d.aluinb = (k inside {K_SHIFTI, K_IALU_S, K_IALU_Z, K_LUI, K_LOAD, K_STORE});
        case (k)
            K_SHIFTI: d.imm = {27'd0, w[10:6]};
            K_IALU_S, K_LOAD, K_STORE, K_BR1, K_BR2: d.imm = {{16{w[15]}}, w[15:0]};
            K_IALU_Z: d.imm = {16'd0, w[15:0]};
            K_LUI:    d.imm = {w[15:0], 16'd0};
            default:  d.imm = 32'd0;
        endcase
        if (k inside {K_J, K_JAL}) d.target = {pc4[31:28], w[25:0], 2'b00};
        return d;
    endfunction

    function automatic logic uses_rt(input logic [31:0] w);
        kind_t k = classify(w);
        return (k inside {K_RALU, K_SHIFTI, K_BR2}) ||
               (w[31:26] == 6'h2b) || (w[31:26] == 6'h28);
    endfunction

    function automatic dec_t observe();
        return {bus.out_pc, bus.out_rs, bus.out_rt, bus.out_dst, bus.out_imm,
                bus.out_target, bus.out_br, bus.out_jp, bus.out_aluinb, bus.out_dmwe,
                bus.out_rwe, bus.out_rwd, bus.out_aluop, bus.out_illegal};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check at the falling edge against the model, advance the model,
    // then return 1 time unit after the rising edge.
    task automatic tick();
        dec_t d;
        logic hz;
        logic rdy;
        @(negedge clock);
        d   = ref_dec(bus.in_insn, bus.in_pc);
        hz  = m_valid && m_q.rwd && m_q.rwe && (m_q.dst != 5'd0) &&
              ((d.rs == m_q.dst) || (uses_rt(bus.in_insn) && (bus.in_insn[20:16] == m_q.dst)));
        rdy = !reset && !bus.flush && !hz && (!m_valid || bus.out_ready);
        chk("in_ready", {127'd0, bus.in_ready}, {127'd0, rdy});
        chk("out_valid", {127'd0, bus.out_valid}, {127'd0, m_valid});
        if (m_valid || m_rst) chk("fields", {4'd0, observe()}, {4'd0, m_q});
        if (reset) begin
            m_valid = 1'b0;
            m_q     = '0;
            m_rst   = 1'b1;
        end else if (bus.flush) begin
            m_valid = 1'b0;
        end else if (bus.in_valid && rdy) begin
            m_q     = d;
            m_valid = 1'b1;
            m_rst   = 1'b0;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w = $urandom;
        int s = $urandom_range(0, 9);
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        w[15:11] = 5'($urandom_range(0, 3));
        if (s < 4) begin
            w[31:26] = 6'h00;
            w[5:0]   = RFN[$urandom_range(0, 23)];
        end else if (s < 9) begin
            w[31:26] = IOP[$urandom_range(0, 23)];
            if (w[31:26] == 6'h1c && $urandom_range(0, 1) == 1) w[5:0] = 6'h02;
        end else if ($urandom_range(0, 1) == 1) begin
            w = 32'd0;
        end
        return w;
    endfunction

    initial begin
        m_valid       = 1'b0;
        m_rst         = 1'b1;
        m_q           = '0;
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h0040_0000;
        bus.in_insn   = 32'h2005_FFFC;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // reset held three cycles with a valid instruction waiting
        repeat (3) tick();
        chk("rst_ready", {127'd0, bus.in_ready}, 128'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready", {127'd0, bus.in_ready}, 128'd1);

        // ADDI $5,$0,-4
        tick();
        chk("addi_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("addi_dst", {123'd0, bus.out_dst}, 128'd5);
        chk("addi_rwe", {127'd0, bus.out_rwe}, 128'd1);
        chk("addi_aluinb", {127'd0, bus.out_aluinb}, 128'd1);
        chk("addi_imm", {96'd0, bus.out_imm}, 128'hFFFF_FFFC);

        // LW $8,0($9) followed by dependent ADD $10,$8,$2
        bus.in_pc   = 32'h0040_0004;
        bus.in_insn = 32'h8D28_0000;
        tick();
        bus.in_pc     = 32'h0040_0008;
        bus.in_insn   = 32'h0102_5020;
        bus.out_ready = 1'b0;
        #1;
        chk("lu_stall_held", {127'd0, bus.in_ready}, 128'd0);
        tick();
        bus.out_ready = 1'b1;
        #1;
        chk("lu_stall_drain", {127'd0, bus.in_ready}, 128'd0);
        tick();
        chk("lu_bubble", {127'd0, bus.out_valid}, 128'd0);
        chk("lu_release", {127'd0, bus.in_ready}, 128'd1);
        tick();
        chk("add_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("add_rs", {123'd0, bus.out_rs}, 128'd8);
        chk("add_dst", {123'd0, bus.out_dst}, 128'd10);

        // ORI $3,$3,0x8000 held for four cycles
        bus.in_pc   = 32'h0040_000C;
        bus.in_insn = 32'h3463_8000;
        tick();
        bus.in_pc     = 32'h0040_0010;
        bus.in_insn   = 32'h0000_0000;
        bus.out_ready = 1'b0;
        repeat (4) begin
            tick();
            chk("ori_imm", {96'd0, bus.out_imm}, 128'h0000_8000);
            chk("ori_ready", {127'd0, bus.in_ready}, 128'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        tick();
        chk("ori_drained", {127'd0, bus.out_valid}, 128'd0);

        // JAL then flush
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h0040_0000;
        bus.in_insn   = 32'h0C10_0000;
        bus.out_ready = 1'b0;
        tick();
        chk("jal_dst", {123'd0, bus.out_dst}, 128'd31);
        chk("jal_jp", {127'd0, bus.out_jp}, 128'd1);
        chk("jal_rwe", {127'd0, bus.out_rwe}, 128'd1);
        chk("jal_target", {96'd0, bus.out_target}, 128'h0040_0000);
        bus.flush   = 1'b1;
        bus.in_insn = 32'h2005_FFFC;
        #1;
        chk("flush_ready", {127'd0, bus.in_ready}, 128'd0);
        tick();
        chk("flush_valid", {127'd0, bus.out_valid}, 128'd0);
        bus.flush = 1'b0;

        // MULT $4,$5
        bus.in_insn   = 32'h0085_0018;
        bus.out_ready = 1'b1;
        tick();
        chk("mult_illegal", {127'd0, bus.out_illegal}, {127'd0, !MD});
        chk("mult_rwe", {127'd0, bus.out_rwe}, 128'd0);
        chk("mult_dmwe", {127'd0, bus.out_dmwe}, 128'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 199) == 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.in_valid  = ($urandom_range(0, 4) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_insn   = rand_insn();
            bus.in_pc     = ($urandom_range(0, 7) == 0) ? 32'h0FFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
